vga_framebuffer_reader: RTL and testbench

//  Display stage downstream of the nearest-neighbour upscaler. Scans a 640x480@60 VGA raster,

---
 rtl/vga_framebuffer_reader.sv | 162 ++++++++++++++++
 tb/tb_vga_framebuffer_reader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_framebuffer_reader.sv
// vga_framebuffer_reader
//   Scans a VGA raster, fetches the upscaled grey image from the framebuffer read port,
//   centres it on screen and drives grey RGB plus active-low syncs. The geometry
//   (scale factor, frame validity) is latched once per frame at raster origin.
// Ports
//   clk          pixel clock
//   reset        asynchronous, active-low
//   fator        scale factor used by the upscaler (0 = no image)
//   frame_valid  framebuffer holds a complete frame
//   ram_rdaddr   registered framebuffer read address (row-major, base 0)
//   ram_q        framebuffer read data, valid by the RAM_LAT-th edge after ram_rdaddr changes
//   vga_r/g/b    grey pixel value, black outside the image window
//   vga_hs/vs    horizontal / vertical sync, active-low
//   vga_blank_n  1 while the pins carry a visible pixel
//   frame_start  one-clk pulse while the raster counters sit at (0,0), not pipelined
module vga_framebuffer_reader #(
  parameter int unsigned H_VIS   = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_VIS   = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33,
  parameter int unsigned IMG_W   = 160,
  parameter int unsigned IMG_H   = 120,
  parameter int unsigned RAM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  fator,
  input  logic        frame_valid,
  output logic [18:0] ram_rdaddr,
  input  logic [7:0]  ram_q,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        frame_start
);

  localparam logic [9:0]  HLast   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  VLast   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  HSyncS  = 10'(H_VIS + H_FP);
  localparam logic [9:0]  HSyncE  = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0]  VSyncS  = 10'(V_VIS + V_FP);
  localparam logic [9:0]  VSyncE  = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0]  HVis10  = 10'(H_VIS);
  localparam logic [9:0]  VVis10  = 10'(V_VIS);
  localparam logic [11:0] HVis12  = 12'(H_VIS);
  localparam logic [11:0] VVis12  = 12'(V_VIS);

  logic [9:0]         r_hcnt, r_vcnt;
  logic               r_show;
  logic [11:0]        r_img_w, r_img_h, r_x0, r_y0;
  logic [18:0]        r_ram_rdaddr;
  logic [RAM_LAT-1:0] r_dly_hs, r_dly_vs, r_dly_blank, r_dly_win;
  logic [7:0]         r_rgb;
  logic               r_hs, r_vs, r_blank_n;

  logic [11:0] w_new_w, w_new_h, w_h12, w_v12;
  logic        w_new_show, w_at_origin, w_in_win;
  logic        w_hs_raw, w_vs_raw, w_blank_raw;
  logic [18:0] w_dx, w_dy, w_addr;

  always_comb begin
    w_new_w     = 12'(IMG_W * fator);
    w_new_h     = 12'(IMG_H * fator);
    w_new_show  = frame_valid && (fator != 3'd0) && (w_new_w <= HVis12) && (w_new_h <= VVis12);
    w_at_origin = (r_hcnt == 10'd0) && (r_vcnt == 10'd0);
    w_h12       = {2'b00, r_hcnt};
    w_v12       = {2'b00, r_vcnt};
    w_in_win    = r_show && (w_h12 >= r_x0) && (w_h12 < r_x0 + r_img_w) &&
                  (w_v12 >= r_y0) && (w_v12 < r_y0 + r_img_h);
    // Offsets are only used inside the window, so the 12-bit differences never underflow.
    w_dx        = {7'd0, w_h12 - r_x0};
    w_dy        = {7'd0, w_v12 - r_y0};
    w_addr      = w_dy * {7'd0, r_img_w} + w_dx;
    w_hs_raw    = !((r_hcnt >= HSyncS) && (r_hcnt < HSyncE));
    w_vs_raw    = !((r_vcnt >= VSyncS) && (r_vcnt < VSyncE));
    w_blank_raw = (r_hcnt < HVis10) && (r_vcnt < VVis10);
  end

  // Raster counters and per-frame geometry latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hcnt  <= '0;
      r_vcnt  <= '0;
      r_show  <= 1'b0;
      r_img_w <= '0;
      r_img_h <= '0;
      r_x0    <= '0;
      r_y0    <= '0;
    end else begin
      if (r_hcnt == HLast) begin
        r_hcnt <= '0;
        r_vcnt <= (r_vcnt == VLast) ? 10'd0 : r_vcnt + 10'd1;
      end else begin
        r_hcnt <= r_hcnt + 10'd1;
      end
      if (w_at_origin) begin
        r_show  <= w_new_show;
        r_img_w <= w_new_w;
        r_img_h <= w_new_h;
        // Garbage when the image does not fit, but then r_show keeps the window closed.
        r_x0    <= (HVis12 - w_new_w) >> 1;
        r_y0    <= (VVis12 - w_new_h) >> 1;
      end
    end
  end

  // Address stage plus sync/blank/window delay matched to the RAM latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ram_rdaddr <= '0;
      r_dly_hs     <= '1;
      r_dly_vs     <= '1;
      r_dly_blank  <= '0;
      r_dly_win    <= '0;
    end else begin
      r_ram_rdaddr   <= w_in_win ? w_addr : 19'd0;
      r_dly_hs[0]    <= w_hs_raw;
      r_dly_vs[0]    <= w_vs_raw;
      r_dly_blank[0] <= w_blank_raw;
      r_dly_win[0]   <= w_in_win;
      for (int unsigned i = 1; i < RAM_LAT; i++) begin
        r_dly_hs[i]    <= r_dly_hs[i-1];
        r_dly_vs[i]    <= r_dly_vs[i-1];
        r_dly_blank[i] <= r_dly_blank[i-1];
        r_dly_win[i]   <= r_dly_win[i-1];
      end
    end
  end

  // Output register: pins lag the counters by RAM_LAT+1 clocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rgb     <= '0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
    end else begin
      r_rgb     <= (r_dly_blank[RAM_LAT-1] && r_dly_win[RAM_LAT-1]) ? ram_q : 8'd0;
      r_hs      <= r_dly_hs[RAM_LAT-1];
      r_vs      <= r_dly_vs[RAM_LAT-1];
      r_blank_n <= r_dly_blank[RAM_LAT-1];
    end
  end

  assign ram_rdaddr  = r_ram_rdaddr;
  assign vga_r       = r_rgb;
  assign vga_g       = r_rgb;
  assign vga_b       = r_rgb;
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vga_blank_n = r_blank_n;
  // Gated by reset so the pulse stays low while reset is held at (0,0).
  assign frame_start = reset && w_at_origin;

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// Testbench for vga_framebuffer_reader on a reduced raster (64x48 visible, 80x55 total,
// 16x12 source image) so whole frames stay short. RAM model returns ram_rdaddr[7:0].
module tb_vga_framebuffer_reader;

  localparam int HT    = 80;
  localparam int VT    = 55;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  fator = 3'd0;
  logic        frame_valid = 1'b0;
  logic [18:0] ram_rdaddr;
  logic [7:0]  ram_q = 8'd0;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, frame_start;

  int n_checks = 0;
  int n_errors = 0;

  // Independent raster position model.
  int m_h = 0;
  int m_v = 0;

  logic [18:0] cap_addr [80];
  logic [7:0]  cap_r [80];
  logic [7:0]  cap_g [80];
  logic [7:0]  cap_b [80];
  logic        cap_hs [80];
  logic        cap_blank [80];

  vga_framebuffer_reader #(
    .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .IMG_W(16), .IMG_H(12), .RAM_LAT(2)
  ) dut (
    .clk(clk), .reset(reset), .fator(fator), .frame_valid(frame_valid),
    .ram_rdaddr(ram_rdaddr), .ram_q(ram_q),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= ram_rdaddr[7:0];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_h <= 0;
      m_v <= 0;
    end else if (m_h == HT - 1) begin
      m_h <= 0;
      m_v <= (m_v == VT - 1) ? 0 : m_v + 1;
    end else begin
      m_h <= m_h + 1;
    end
  end

  // Returns at a negedge where the counters sit at (h,v).
  task automatic wait_pos(input int h, input int v);
    int guard = 0;
    while (!(m_h == h && m_v == v)) begin
      @(negedge clk);
      guard++;
      if (guard > 2 * FRAME) begin
        $display("FAIL wait_pos(%0d,%0d) timeout, got pos (%0d,%0d)", h, v, m_h, m_v);
        $fatal(1);
      end
    end
  endtask

  // Records address (1 clk later) and pins (3 clk later) for n pixels starting at (h,v).
  task automatic capture(input int h, input int v, input int n);
    wait_pos(h, v);
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      if (k - 1 < n) cap_addr[k-1] = ram_rdaddr;
      if (k >= 3) begin
        cap_r[k-3] = vga_r; cap_g[k-3] = vga_g; cap_b[k-3] = vga_b;
        cap_hs[k-3] = vga_hs; cap_blank[k-3] = vga_blank_n;
      end
    end
  endtask

  task automatic test_reset;
    logic [50:0] obs;
    reset = 1'b0; fator = 3'd4; frame_valid = 1'b1;
    repeat (3) @(negedge clk);
    obs = {ram_rdaddr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start};
    n_checks++;
    if (obs !== {19'd0, 24'd0, 4'b1100})
      begin n_errors++; $display("FAIL reset_values got %h want %h", obs, {19'd0, 24'd0, 4'b1100}); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (frame_start !== 1'b1)
      begin n_errors++; $display("FAIL fs_after_release got %b want 1", frame_start); end
    @(negedge clk);
    n_checks++;
    if (frame_start !== 1'b0)
      begin n_errors++; $display("FAIL fs_second_clk got %b want 0", frame_start); end
  endtask

  task automatic test_full_screen;
    logic [18:0] ea [3];
    logic [7:0]  er [3];
    logic        eb [3];
    int bad;
    capture(0, 0, 2);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (cap_addr[i] !== 19'(i) || cap_r[i] !== 8'(i) || cap_blank[i] !== 1'b1)
        begin n_errors++; $display("FAIL full_origin[%0d] got addr=%0d rgb=%0d blank=%b want %0d %0d 1",
                                   i, cap_addr[i], cap_r[i], cap_blank[i], i, i); end
    end
    capture(0, 2, 64);
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (cap_r[i] !== 8'(128 + i) || cap_g[i] !== cap_r[i] || cap_b[i] !== cap_r[i] ||
          cap_r[i] == 8'd0 || cap_blank[i] !== 1'b1) bad++;
    n_checks++;
    if (bad !== 0) begin n_errors++; $display("FAIL full_line2 got %0d bad pixels want 0", bad); end
    capture(5, 3, 1);
    n_checks++;
    if (cap_addr[0] !== 19'd197 || cap_r[0] !== 8'd197)
      begin n_errors++; $display("FAIL full_5_3 got addr=%0d rgb=%0d want 197 197", cap_addr[0], cap_r[0]); end
    capture(62, 47, 3);
    ea = '{19'd3070, 19'd3071, 19'd0}; er = '{8'd254, 8'd255, 8'd0}; eb = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (cap_addr[i] !== ea[i] || cap_r[i] !== er[i] || cap_blank[i] !== eb[i])
        begin n_errors++; $display("FAIL full_corner[%0d] got addr=%0d rgb=%0d blank=%b want %0d %0d %b",
                                   i, cap_addr[i], cap_r[i], cap_blank[i], ea[i], er[i], eb[i]); end
    end
  endtask

  task automatic test_fator3;
    logic [18:0] ea [3];
    logic [7:0]  er [3];
    fator = 3'd3;
    wait_pos(0, 0);
    capture(8, 5, 1);
    n_checks++;
    if (cap_addr[0] !== 19'd0 || cap_r[0] !== 8'd0 || cap_blank[0] !== 1'b1)
      begin n_errors++; $display("FAIL f3_above got addr=%0d rgb=%0d blank=%b want 0 0 1",
                                 cap_addr[0], cap_r[0], cap_blank[0]); end
    capture(7, 6, 3);
    ea = '{19'd0, 19'd0, 19'd1}; er = '{8'd0, 8'd0, 8'd1};
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (cap_addr[i] !== ea[i] || cap_r[i] !== er[i])
        begin n_errors++; $display("FAIL f3_left[%0d] got addr=%0d rgb=%0d want %0d %0d",
                                   i, cap_addr[i], cap_r[i], ea[i], er[i]); end
    end
    capture(20, 10, 1);
    n_checks++;
    if (cap_addr[0] !== 19'd204 || cap_r[0] !== 8'd204)
      begin n_errors++; $display("FAIL f3_mid got addr=%0d rgb=%0d want 204 204", cap_addr[0], cap_r[0]); end
    capture(54, 41, 3);
    ea = '{19'd1726, 19'd1727, 19'd0}; er = '{8'd190, 8'd191, 8'd0};
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (cap_addr[i] !== ea[i] || cap_r[i] !== er[i])
        begin n_errors++; $display("FAIL f3_right[%0d] got addr=%0d rgb=%0d want %0d %0d",
                                   i, cap_addr[i], cap_r[i], ea[i], er[i]); end
    end
  endtask

  task automatic test_timing;
    int fs_cnt = 0, fs_at = 0, hs_lo = 0, vs_lo = 0, bl = 0, hl = 0, bll = 0;
    wait_pos(0, 0);
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      if (frame_start) begin fs_cnt++; fs_at = k; end
      if (!vga_hs) hs_lo++;
      if (!vga_vs) vs_lo++;
      if (vga_blank_n) bl++;
    end
    n_checks++;
    if (fs_cnt !== 1 || fs_at !== FRAME)
      begin n_errors++; $display("FAIL fs_period got count=%0d at=%0d want 1 %0d", fs_cnt, fs_at, FRAME); end
    n_checks++;
    if (hs_lo !== 440) begin n_errors++; $display("FAIL hs_frame got %0d want 440", hs_lo); end
    n_checks++;
    if (vs_lo !== 160) begin n_errors++; $display("FAIL vs_frame got %0d want 160", vs_lo); end
    n_checks++;
    if (bl !== 3072) begin n_errors++; $display("FAIL blank_frame got %0d want 3072", bl); end
    capture(0, 10, 80);
    for (int i = 0; i < 80; i++) begin
      if (!cap_hs[i]) hl++;
      if (cap_blank[i]) bll++;
    end
    n_checks++;
    if (hl !== 8 || cap_hs[67] !== 1'b1 || cap_hs[68] !== 1'b0 || cap_hs[75] !== 1'b0 ||
        cap_hs[76] !== 1'b1)
      begin n_errors++; $display("FAIL hs_line got low=%0d edges=%b%b%b%b want 8 1001",
                                 hl, cap_hs[67], cap_hs[68], cap_hs[75], cap_hs[76]); end
    n_checks++;
    if (bll !== 64 || cap_blank[63] !== 1'b1 || cap_blank[64] !== 1'b0)
      begin n_errors++; $display("FAIL blank_line got %0d want 64", bll); end
  endtask

  task automatic test_black_frames;
    logic [2:0] fv [3];
    logic       vv [3];
    int nz_a, nz_c, bl;
    fv = '{3'd5, 3'd0, 3'd4}; vv = '{1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 3; c++) begin
      fator = fv[c]; frame_valid = vv[c];
      wait_pos(0, 0);
      nz_a = 0; nz_c = 0; bl = 0;
      for (int k = 1; k <= FRAME; k++) begin
        @(negedge clk);
        if (ram_rdaddr != 19'd0) nz_a++;
        if ((vga_r | vga_g | vga_b) != 8'd0) nz_c++;
        if (vga_blank_n) bl++;
      end
      n_checks++;
      if (nz_a !== 0 || nz_c !== 0 || bl !== 3072)
        begin n_errors++; $display("FAIL black_cfg%0d got nz_addr=%0d nz_rgb=%0d blank=%0d want 0 0 3072",
                                   c, nz_a, nz_c, bl); end
    end
  endtask

  task automatic test_midframe_change;
    logic [18:0] ea [3];
    logic [7:0]  er [3];
    fator = 3'd4; frame_valid = 1'b1;
    wait_pos(0, 0);
    wait_pos(0, 20);
    fator = 3'd2; frame_valid = 1'b0;
    capture(5, 30, 1);
    n_checks++;
    if (cap_addr[0] !== 19'd1925 || cap_r[0] !== 8'd133)
      begin n_errors++; $display("FAIL mid_same_frame got addr=%0d rgb=%0d want 1925 133", cap_addr[0], cap_r[0]); end
    capture(20, 15, 1);
    n_checks++;
    if (cap_addr[0] !== 19'd0 || cap_r[0] !== 8'd0 || cap_blank[0] !== 1'b1)
      begin n_errors++; $display("FAIL mid_next_black got addr=%0d rgb=%0d want 0 0", cap_addr[0], cap_r[0]); end
    frame_valid = 1'b1;
    wait_pos(0, 0);
    capture(15, 12, 3);
    ea = '{19'd0, 19'd0, 19'd1}; er = '{8'd0, 8'd0, 8'd1};
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (cap_addr[i] !== ea[i] || cap_r[i] !== er[i])
        begin n_errors++; $display("FAIL f2_left[%0d] got addr=%0d rgb=%0d want %0d %0d",
                                   i, cap_addr[i], cap_r[i], ea[i], er[i]); end
    end
    capture(47, 35, 2);
    ea = '{19'd767, 19'd0, 19'd0}; er = '{8'd255, 8'd0, 8'd0};
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (cap_addr[i] !== ea[i] || cap_r[i] !== er[i])
        begin n_errors++; $display("FAIL f2_corner[%0d] got addr=%0d rgb=%0d want %0d %0d",
                                   i, cap_addr[i], cap_r[i], ea[i], er[i]); end
    end
  endtask

  task automatic test_reset_midframe;
    logic [50:0] obs;
    int first_lo = -1;
    wait_pos(30, 20);
    n_checks++;
    if (ram_rdaddr !== 19'd269)
      begin n_errors++; $display("FAIL rst_pre_addr got %0d want 269", ram_rdaddr); end
    reset = 1'b0;
    #1;
    obs = {ram_rdaddr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start};
    n_checks++;
    if (obs !== {19'd0, 24'd0, 4'b1100})
      begin n_errors++; $display("FAIL rst_mid_immediate got %h want %h", obs, {19'd0, 24'd0, 4'b1100}); end
    repeat (3) @(negedge clk);
    obs = {ram_rdaddr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start};
    n_checks++;
    if (obs !== {19'd0, 24'd0, 4'b1100})
      begin n_errors++; $display("FAIL rst_mid_held got %h want %h", obs, {19'd0, 24'd0, 4'b1100}); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (frame_start !== 1'b1)
      begin n_errors++; $display("FAIL rst_mid_fs got %b want 1", frame_start); end
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (!vga_hs) begin first_lo = k; break; end
    end
    n_checks++;
    if (first_lo !== 71)
      begin n_errors++; $display("FAIL rst_mid_restart got hs low at clk %0d want 71", first_lo); end
    capture(16, 12, 2);
    n_checks++;
    if (cap_addr[0] !== 19'd0 || cap_addr[1] !== 19'd1 || cap_r[1] !== 8'd1)
      begin n_errors++; $display("FAIL rst_mid_window got addr=%0d,%0d rgb=%0d want 0,1 1",
                                 cap_addr[0], cap_addr[1], cap_r[1]); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_full_screen();
    test_fator3();
    test_timing();
    test_black_frames();
    test_midframe_change();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
